coeff_token_ctrl: RTL and testbench

COEFF_TOKEN_CTRL -- requirements
Module: coeff_token_ctrl

---
 rtl/coeff_token_ctrl.sv | 114 +++++++++++
 tb/tb_coeff_token_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_token_ctrl.sv
// coeff_token_ctrl: coeff_token decode sequencer (leading-zero count, shared LUT bank lookup, result handshake).
// Optional COEFF_TOKEN_FLC_EN: table-3 requests use the 6-bit fixed-length code path instead of the LUT.
module coeff_token_ctrl (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Start,
  output logic        Ready,
  input  logic [4:0]  nC,
  input  logic        ChromaDC,
  input  logic [15:0] BitWindow,
  output logic [2:0]  LutSel,
  output logic [3:0]  LutPrefix,
  output logic [2:0]  LutSuffix,
  input  logic        LutHit,
  input  logic [4:0]  LutTotalCoeff,
  input  logic [1:0]  LutTrailingOnes,
  input  logic [1:0]  LutSufLen,
  output logic [4:0]  TotalCoeff,
  output logic [1:0]  TrailingOnes,
  output logic [4:0]  BitsUsed,
  output logic        Error,
  output logic        Valid,
  input  logic        Ack
);
  typedef enum logic [1:0] {IDLE, COUNT, LOOKUP, DONE} state_t;
  state_t      state;
  logic [15:0] win;
  logic [3:0]  z;
  logic [2:0]  sel;
  logic [2:0]  tbl;
  assign tbl = ChromaDC ? 3'd4 : nC < 5'd2 ? 3'd0 : nC < 5'd4 ? 3'd1 : nC < 5'd8 ? 3'd2 : 3'd3;
`ifdef COEFF_TOKEN_FLC_EN
  logic [5:0] code;
  logic [4:0] flc_tc;
  logic [1:0] flc_t1;
  logic       flc_err;
  assign code    = win[15:10];
  assign flc_tc  = code == 6'b000011 ? 5'd0 : {1'b0, code[5:2]} + 5'd1;
  assign flc_t1  = code == 6'b000011 ? 2'd0 : code[1:0];
  assign flc_err = {3'b000, flc_t1} > flc_tc;
`endif
  // win shifts left while counting, so win[15] is always the bit under test
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      Ready        <= 1'b1;
      Valid        <= 1'b0;
      win          <= '0;
      z            <= '0;
      sel          <= '0;
      LutSel       <= '0;
      LutPrefix    <= '0;
      LutSuffix    <= '0;
      TotalCoeff   <= '0;
      TrailingOnes <= '0;
      BitsUsed     <= '0;
      Error        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          state <= COUNT;
          Ready <= 1'b0;
          win   <= BitWindow;
          sel   <= tbl;
          z     <= '0;
        end
        COUNT:
`ifdef COEFF_TOKEN_FLC_EN
          if (sel == 3'd3) begin
            state        <= DONE;
            Valid        <= 1'b1;
            Error        <= flc_err;
            TotalCoeff   <= flc_err ? 5'd0 : flc_tc;
            TrailingOnes <= flc_err ? 2'd0 : flc_t1;
            BitsUsed     <= flc_err ? 5'd0 : 5'd6;
          end else
`endif
          if (win[15]) begin
            state     <= LOOKUP;
            LutSel    <= sel;
            LutPrefix <= z;
            LutSuffix <= win[14:12];
          end else if (z == 4'd15) begin
            state        <= DONE;
            Valid        <= 1'b1;
            Error        <= 1'b1;
            TotalCoeff   <= '0;
            TrailingOnes <= '0;
            BitsUsed     <= '0;
          end else begin
            win <= {win[14:0], 1'b0};
            z   <= z + 4'd1;
          end
        LOOKUP: begin
          state        <= DONE;
          Valid        <= 1'b1;
          LutSel       <= '0;
          LutPrefix    <= '0;
          LutSuffix    <= '0;
          Error        <= !LutHit;
          TotalCoeff   <= LutHit ? LutTotalCoeff : 5'd0;
          TrailingOnes <= LutHit ? LutTrailingOnes : 2'd0;
          BitsUsed     <= LutHit ? {1'b0, z} + 5'd1 + {3'b000, LutSufLen} : 5'd0;
        end
        DONE: if (Ack) begin
          state <= IDLE;
          Valid <= 1'b0;
          Ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coeff_token_ctrl.sv
// tb_coeff_token_ctrl: directed vectors against a timeline model of coeff_token_ctrl.
// The model derives every expectation from captured request fields plus the cycle count since accept.
module tb_coeff_token_ctrl;
  logic        Clk = 1'b0;
  logic        nReset, Start, ChromaDC, Ack;
  logic [4:0]  nC;
  logic [15:0] BitWindow;
  logic [2:0]  LutSel;
  logic [3:0]  LutPrefix;
  logic [2:0]  LutSuffix;
  logic        LutHit;
  logic [4:0]  LutTotalCoeff;
  logic [1:0]  LutTrailingOnes, LutSufLen;
  logic [4:0]  TotalCoeff, BitsUsed;
  logic [1:0]  TrailingOnes;
  logic        Error, Valid, Ready;

  coeff_token_ctrl dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .Ready(Ready), .nC(nC), .ChromaDC(ChromaDC),
    .BitWindow(BitWindow), .LutSel(LutSel), .LutPrefix(LutPrefix), .LutSuffix(LutSuffix),
    .LutHit(LutHit), .LutTotalCoeff(LutTotalCoeff), .LutTrailingOnes(LutTrailingOnes),
    .LutSufLen(LutSufLen), .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes),
    .BitsUsed(BitsUsed), .Error(Error), .Valid(Valid), .Ack(Ack)
  );

  always #5 Clk = ~Clk;

  int ncmp = 0;
  int nerr = 0;
  int r_lat, r_sel, r_pfx, r_sfx, r_tc, r_t1, r_bu, r_er;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // captured request and LUT response, plus cycles since accept
  logic        m_busy = 1'b0, m_fresh = 1'b1;
  int          m_n = 0;
  logic [4:0]  c_nc = '0, c_tc = '0;
  logic        c_cdc = 1'b0, c_hit = 1'b0;
  logic [15:0] c_win = '0;
  logic [1:0]  c_t1 = '0, c_sl = '0;

  function automatic int f_sel();
    return c_cdc ? 4 : c_nc < 2 ? 0 : c_nc < 4 ? 1 : c_nc < 8 ? 2 : 3;
  endfunction
  function automatic int f_z();
    for (int i = 15; i >= 0; i--) if (c_win[i]) return 15 - i;
    return 16;
  endfunction
  function automatic bit f_flc();
`ifdef COEFF_TOKEN_FLC_EN
    return f_sel() == 3;
`else
    return 1'b0;
`endif
  endfunction
  function automatic int f_lat();
    return f_flc() ? 2 : f_z() == 16 ? 17 : f_z() + 3;
  endfunction

  always @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      m_busy  <= 1'b0;
      m_n     <= 0;
      m_fresh <= 1'b1;
    end else if (!m_busy) begin
      if (Start) begin
        m_busy <= 1'b1; m_n <= 1; m_fresh <= 1'b0;
        c_nc <= nC; c_cdc <= ChromaDC; c_win <= BitWindow;
        c_hit <= LutHit; c_tc <= LutTotalCoeff; c_t1 <= LutTrailingOnes; c_sl <= LutSufLen;
      end
    end else if (Ack && m_n >= f_lat()) m_busy <= 1'b0;
    else m_n <= m_n + 1;
  end

  always @(negedge Clk) if (nReset === 1'b1) begin : cmp
    int sel, z, lat, lutn, sfx, etc, et1, ebu, eer, w;
    bit v, la, flc;
    logic [5:0] code;
    sel = f_sel(); z = f_z(); lat = f_lat(); flc = f_flc();
    if (flc) begin
      code = c_win[15:10];
      etc = code == 6'd3 ? 0 : int'(code[5:2]) + 1;
      et1 = code == 6'd3 ? 0 : int'(code[1:0]);
      eer = et1 > etc; ebu = 6;
    end else if (z == 16) begin
      eer = 1; etc = 0; et1 = 0; ebu = 0;
    end else begin
      eer = !c_hit; etc = c_tc; et1 = c_t1; ebu = z + 1 + c_sl;
    end
    if (eer != 0) begin etc = 0; et1 = 0; ebu = 0; end
    w = c_win;
    w = (w << (z + 1)) & 32'hFFFF;
    sfx = w >> 13;
    lutn = (flc || z == 16) ? -1 : z + 2;
    v  = m_busy && m_n >= lat;
    la = m_busy && m_n == lutn;
    chk("ready", Ready, !m_busy);
    chk("valid", Valid, v);
    chk("lut_sel", LutSel, la ? sel : 0);
    chk("lut_prefix", LutPrefix, la ? z : 0);
    chk("lut_suffix", LutSuffix, la ? sfx : 0);
    if (v) begin
      chk("total_coeff", TotalCoeff, etc);
      chk("trailing_ones", TrailingOnes, et1);
      chk("bits_used", BitsUsed, ebu);
      chk("error", Error, eer);
    end
    if (m_fresh) begin
      chk("rst_tc", TotalCoeff, 0);
      chk("rst_t1", TrailingOnes, 0);
      chk("rst_bu", BitsUsed, 0);
      chk("rst_err", Error, 0);
    end
  end

  task automatic wait_done(input int hold, input bit sid, input bit ae);
    int cnt;
    cnt = 1; r_sel = 0; r_pfx = 0; r_sfx = 0;
    @(negedge Clk);
    Start = 1'b0; Ack = ae; nC = ~nC; BitWindow = ~BitWindow; ChromaDC = ~ChromaDC;
    while (Valid !== 1'b1 && cnt < 40) begin
      if (LutSel != 0 || LutPrefix != 0 || LutSuffix != 0) begin
        r_sel = LutSel; r_pfx = LutPrefix; r_sfx = LutSuffix;
      end
      @(posedge Clk);
      cnt++;
      @(negedge Clk);
      Ack = 1'b0;
    end
    chk("valid_seen", Valid, 1);
    r_lat = cnt; r_tc = TotalCoeff; r_t1 = TrailingOnes; r_bu = BitsUsed; r_er = Error;
    Start = sid;
    repeat (hold) @(negedge Clk);
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0; Start = 1'b0;
    chk("ready_after_ack", Ready, 1);
  endtask

  task automatic txn(input logic [4:0] nc, input logic cdc, input logic [15:0] win, input logic hit,
                     input logic [4:0] tc, input logic [1:0] t1, input logic [1:0] sl,
                     input int hold, input bit sid, input bit ae);
    @(negedge Clk);
    nC = nc; ChromaDC = cdc; BitWindow = win;
    LutHit = hit; LutTotalCoeff = tc; LutTrailingOnes = t1; LutSufLen = sl;
    Start = 1'b1;
    @(posedge Clk);
    wait_done(hold, sid, ae);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0; Start = 1'b0; Ack = 1'b0; nC = '0; ChromaDC = 1'b0; BitWindow = '0;
    LutHit = 1'b0; LutTotalCoeff = '0; LutTrailingOnes = '0; LutSufLen = '0;
    repeat (2) @(negedge Clk);
    chk("init_ready", Ready, 1); chk("init_valid", Valid, 0); chk("init_err", Error, 0);
    chk("init_tc", TotalCoeff, 0); chk("init_bu", BitsUsed, 0); chk("init_lutsel", LutSel, 0);
    #2 nReset = 1'b1;

    txn(5'd0, 1'b0, 16'h8000, 1'b1, 5'd0, 2'd0, 2'd0, 1, 1'b0, 1'b0);
    chk("v1_lat", r_lat, 3); chk("v1_tc", r_tc, 0); chk("v1_bu", r_bu, 1); chk("v1_err", r_er, 0);

    txn(5'd2, 1'b0, 16'h1A00, 1'b1, 5'd3, 2'd1, 2'd2, 2, 1'b0, 1'b0);
    chk("v2_lat", r_lat, 6); chk("v2_sel", r_sel, 1); chk("v2_pfx", r_pfx, 3);
    chk("v2_sfx", r_sfx, 5); chk("v2_bu", r_bu, 6); chk("v2_tc", r_tc, 3);

    txn(5'd4, 1'b0, 16'h0000, 1'b1, 5'd5, 2'd1, 2'd1, 0, 1'b0, 1'b1);
    chk("v3_lat", r_lat, 17); chk("v3_err", r_er, 1); chk("v3_tc", r_tc, 0); chk("v3_bu", r_bu, 0);

    txn(5'd9, 1'b0, 16'h0C00, 1'b1, 5'd7, 2'd2, 2'd1, 1, 1'b0, 1'b0);
`ifdef COEFF_TOKEN_FLC_EN
    chk("v4_lat", r_lat, 2); chk("v4_tc", r_tc, 0); chk("v4_t1", r_t1, 0); chk("v4_bu", r_bu, 6);
`else
    chk("v4_lat", r_lat, 7); chk("v4_sel", r_sel, 3); chk("v4_pfx", r_pfx, 4);
    chk("v4_sfx", r_sfx, 4); chk("v4_tc", r_tc, 7); chk("v4_bu", r_bu, 6);
`endif

    txn(5'd9, 1'b1, 16'h4000, 1'b1, 5'd1, 2'd1, 2'd1, 0, 1'b0, 1'b0);
    chk("v5_sel", r_sel, 4); chk("v5_lat", r_lat, 4); chk("v5_bu", r_bu, 3);

    txn(5'd5, 1'b0, 16'h2F00, 1'b0, 5'd9, 2'd3, 2'd2, 0, 1'b0, 1'b0);
    chk("v6_sfx", r_sfx, 3); chk("v6_err", r_er, 1); chk("v6_tc", r_tc, 0); chk("v6_bu", r_bu, 0);

    txn(5'd16, 1'b0, 16'h0001, 1'b1, 5'd16, 2'd3, 2'd3, 3, 1'b1, 1'b0);
`ifdef COEFF_TOKEN_FLC_EN
    chk("v7_tc", r_tc, 1); chk("v7_bu", r_bu, 6);
`else
    chk("v7_lat", r_lat, 18); chk("v7_pfx", r_pfx, 15); chk("v7_bu", r_bu, 19); chk("v7_tc", r_tc, 16);
`endif

    txn(5'd3, 1'b0, 16'h0007, 1'b1, 5'd2, 2'd2, 2'd0, 0, 1'b0, 1'b0);
    chk("v8_lat", r_lat, 16); chk("v8_sfx", r_sfx, 6); chk("v8_bu", r_bu, 14);

    txn(5'd8, 1'b0, 16'h0800, 1'b1, 5'd4, 2'd0, 2'd3, 1, 1'b0, 1'b0);
`ifdef COEFF_TOKEN_FLC_EN
    chk("v9_err", r_er, 1); chk("v9_bu", r_bu, 0);
`else
    chk("v9_err", r_er, 0); chk("v9_bu", r_bu, 8);
`endif

    @(negedge Clk);
    nC = 5'd1; ChromaDC = 1'b0; BitWindow = 16'h0000; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    #2 nReset = 1'b0;
    #1;
    chk("rst_mid_ready", Ready, 1); chk("rst_mid_valid", Valid, 0);
    chk("rst_mid_err", Error, 0); chk("rst_mid_bu", BitsUsed, 0);
    nC = 5'd2; BitWindow = 16'h1A00;
    LutHit = 1'b1; LutTotalCoeff = 5'd3; LutTrailingOnes = 2'd1; LutSufLen = 2'd2;
    Start = 1'b1;
    @(negedge Clk);
    #2 nReset = 1'b1;
    @(posedge Clk);
    #1 chk("accept_after_rst", Ready, 0);
    wait_done(0, 1'b0, 1'b0);
    chk("v10_lat", r_lat, 6); chk("v10_bu", r_bu, 6);

    repeat (2) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
